// File: rtl/arith_pkg.sv
// Shared opcodes, status struct and width-independent constant helpers
// for the pipelined arithmetic unit.
package arith_pkg;

  // Opcode encodings carried on the 3-bit code field.
  localparam logic [2:0] OP_SADD = 3'b000;
  localparam logic [2:0] OP_UADD = 3'b001;
  localparam logic [2:0] OP_SSUB = 3'b010;
  localparam logic [2:0] OP_USUB = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_ACC  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  // Widest operand the constant helpers can describe.
  localparam int MAX_WIDTH = 64;

  // Per-result status bits registered alongside C.
  typedef struct packed {
    logic vout;
    logic cout;
    logic err;
  } flags_t;

  // Largest two's-complement value of a w-bit word, zero-extended.
  function automatic logic [MAX_WIDTH-1:0] signed_max(input int w);
    return (MAX_WIDTH'(1) << (w - 1)) - MAX_WIDTH'(1);
  endfunction

  // Most negative two's-complement value of a w-bit word, zero-extended.
  function automatic logic [MAX_WIDTH-1:0] signed_min(input int w);
    return MAX_WIDTH'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/arith_if.sv
// Operand and result channels of the arithmetic pipeline.
//
// Handshake: a beat moves on a rising edge exactly when its valid and
// ready are both high on that edge. The producer holds valid and payload
// stable until that edge; ready may depend combinationally on the
// consumer's state but never on the same channel's valid.
//   in_valid/in_ready   : operand channel, upstream -> block
//   out_valid/out_ready : result channel, block -> downstream
interface arith_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       code;
  logic             cin;
  logic             coe;
  logic             sat;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             vout;
  logic             cout;
  logic             err;
  logic             ovf_sticky;
  logic             carry_sticky;

  modport master (
    output in_valid, A, B, code, cin, coe, sat, clr, out_ready,
    input  in_ready, out_valid, C, vout, cout, err, ovf_sticky, carry_sticky
  );

  modport slave (
    input  in_valid, A, B, code, cin, coe, sat, clr, out_ready,
    output in_ready, out_valid, C, vout, cout, err, ovf_sticky, carry_sticky
  );
endinterface

// File: rtl/arith_core.sv
// Combinational datapath: WIDTH+1-bit add with operand steering per
// opcode, overflow/carry detection and optional saturation. Carry/overflow
// enable masking is left to the caller.
module arith_core
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       code,
  input  logic             cin,
  input  logic             sat,
  output logic [WIDTH-1:0] C,
  output logic             vout,
  output logic             cout,
  output logic             err
);

  localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));

  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             carry_in;
  logic             is_signed;
  logic             illegal;
  logic [WIDTH:0]   total;
  logic [WIDTH-1:0] raw;
  logic             ovf;

  // Steer operands and carry-in so every opcode is a single op1+op2+carry.
  always_comb begin
    op1       = A;
    op2       = B;
    carry_in  = cin;
    is_signed = 1'b0;
    illegal   = 1'b0;
    case (code)
      OP_SADD: is_signed = 1'b1;
      OP_UADD: is_signed = 1'b0;
      OP_SSUB: begin
        op2       = ~B;
        is_signed = 1'b1;
      end
      OP_USUB: op2 = ~B;
      OP_INC: begin
        op2       = '0;
        carry_in  = 1'b1;
        is_signed = 1'b1;
      end
      OP_DEC: begin
        op2       = '1;
        carry_in  = 1'b0;
        is_signed = 1'b1;
      end
      OP_ACC: begin
        op1       = acc;
        op2       = A;
        is_signed = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign total = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, carry_in};
  assign raw   = total[WIDTH-1:0];

  // Signed overflow; with op2 = ~B the add rule is the subtract rule.
  always_comb begin
    case (code)
      OP_INC:  ovf = (A == SMAX);
      OP_DEC:  ovf = (A == SMIN);
      default: ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (raw[WIDTH-1] != op1[WIDTH-1]);
    endcase
  end

  // Final result: illegal forces zero, saturation clamps, flags stay raw.
  always_comb begin
    C    = raw;
    vout = ovf;
    cout = total[WIDTH];
    err  = illegal;
    if (illegal) begin
      C    = '0;
      vout = 1'b0;
      cout = 1'b0;
    end else if (sat) begin
      if (is_signed && ovf) begin
        C = op1[WIDTH-1] ? SMIN : SMAX;
      end else if (code == OP_UADD && total[WIDTH]) begin
        C = '1;
      end else if (code == OP_USUB && !total[WIDTH]) begin
        C = '0;
      end
    end
  end

endmodule

// File: rtl/arith_pipe.sv
// Two-stage arithmetic pipeline: S1 registers the accepted beat, S2
// registers the computed result. Owns the handshake, the accumulator and
// the sticky overflow/carry flags.
module arith_pipe
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  arith_if.slave bus
);

  logic             en;
  logic             load;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_code;
  logic             s1_cin;
  logic             s1_coe;
  logic             s1_sat;

  logic [WIDTH-1:0] core_c;
  logic             core_v;
  logic             core_co;
  logic             core_err;
  flags_t           next_flags;

  logic             out_valid_q;
  logic [WIDTH-1:0] c_q;
  flags_t           flags_q;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_st_q;
  logic             carry_st_q;

  // Whole pipe advances together unless a held result is not taken.
  assign en            = !out_valid_q || bus.out_ready;
  assign load          = en && s1_valid;
  assign bus.in_ready  = en;

  arith_core #(.WIDTH(WIDTH)) u_core (
    .A    (s1_a),
    .B    (s1_b),
    .acc  (acc_q),
    .code (s1_code),
    .cin  (s1_cin),
    .sat  (s1_sat),
    .C    (core_c),
    .vout (core_v),
    .cout (core_co),
    .err  (core_err)
  );

  // coe=0 hides the flags so the stickies cannot see them either.
  always_comb begin
    next_flags.vout = core_v && s1_coe;
    next_flags.cout = core_co && s1_coe;
    next_flags.err  = core_err;
  end

  // S1: capture the operand beat on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_code  <= '0;
      s1_cin   <= 1'b0;
      s1_coe   <= 1'b0;
      s1_sat   <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a    <= bus.A;
        s1_b    <= bus.B;
        s1_code <= bus.code;
        s1_cin  <= bus.cin;
        s1_coe  <= bus.coe;
        s1_sat  <= bus.sat;
      end
    end
  end

  // S2: register the computed result and its status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      flags_q     <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        c_q     <= core_c;
        flags_q <= next_flags;
      end
    end
  end

  // Accumulator follows every legal result; clr only applies otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (load && !core_err) begin
      acc_q <= core_c;
    end else if (bus.clr) begin
      acc_q <= '0;
    end
  end

  // Sticky flags: a flag set by the loading result survives a same-cycle clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_st_q   <= 1'b0;
      carry_st_q <= 1'b0;
    end else begin
      ovf_st_q   <= (bus.clr ? 1'b0 : ovf_st_q)   | (load && next_flags.vout);
      carry_st_q <= (bus.clr ? 1'b0 : carry_st_q) | (load && next_flags.cout);
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.C            = c_q;
  assign bus.vout         = flags_q.vout;
  assign bus.cout         = flags_q.cout;
  assign bus.err          = flags_q.err;
  assign bus.ovf_sticky   = ovf_st_q;
  assign bus.carry_sticky = carry_st_q;

endmodule

// File: tb/tb_arith_pipe.sv
// Directed bench for arith_pipe: driver pushes hand-computed results into
// an expected queue, a monitor pops and compares on every output handshake.
module tb_arith_pipe;
  import arith_pkg::*;

  localparam int W  = 16;
  localparam int EW = W + 5;

  logic clk;
  logic rst_n;

  arith_if #(.WIDTH(W)) bus ();

  arith_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [EW-1:0] exp_q[$];
  int            n_cmp;
  int            n_bad;
  logic          m_ovf;
  logic          m_carry;
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_got;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // driver: present one beat, wait for acceptance, push the expected result
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic co, input logic sa,
                      input logic [W-1:0] e_c, input logic e_v, input logic e_cy,
                      input logic e_err, input bit push);
    bit done;
    done         = 1'b0;
    bus.code     = op;
    bus.A        = a;
    bus.B        = b;
    bus.cin      = ci;
    bus.coe      = co;
    bus.sat      = sa;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 100 cycles");
    end else if (push) begin
      m_ovf   = m_ovf | e_v;
      m_carry = m_carry | e_cy;
      exp_q.push_back({e_c, e_v, e_cy, e_err, m_ovf, m_carry});
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    check1("drain_empty", exp_q.size() == 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    m_ovf   = 1'b0;
    m_carry = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        mon_got = {bus.C, bus.vout, bus.cout, bus.err, bus.ovf_sticky, bus.carry_sticky};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL result: unexpected output C=0x%h, required no output", bus.C);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_bad++;
            $display("FAIL result: got C=0x%h v=%b c=%b err=%b ovf_st=%b carry_st=%b, expected C=0x%h v=%b c=%b err=%b ovf_st=%b carry_st=%b",
                     mon_got[EW-1:5], mon_got[4], mon_got[3], mon_got[2], mon_got[1], mon_got[0],
                     mon_exp[EW-1:5], mon_exp[4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    m_ovf         = 1'b0;
    m_carry       = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.code      = OP_SADD;
    bus.cin       = 1'b0;
    bus.coe       = 1'b1;
    bus.sat       = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    checkw("rst_C", bus.C, 16'h0000);
    check1("rst_vout", bus.vout, 1'b0);
    check1("rst_cout", bus.cout, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    check1("rst_ovf_sticky", bus.ovf_sticky, 1'b0);
    check1("rst_carry_sticky", bus.carry_sticky, 1'b0);
    check1("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // signed overflow, then latency: valid only after the second edge
    send(OP_SADD, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    check1("lat_edge1_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    check1("lat_edge2_valid", bus.out_valid, 1'b1);
    check1("lat_edge2_ovf_sticky", bus.ovf_sticky, 1'b1);
    send(OP_SADD, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
    send(OP_USUB, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    send(OP_USUB, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(OP_UADD, 16'hFFFF, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // clear, then back-to-back accumulate chain
    do_clr();
    send(OP_ACC, 16'h0005, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1);
    send(OP_ACC, 16'h0007, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1);
    send(OP_ACC, 16'hFFFF, 16'h3333, 1'b0, 1'b1, 1'b0, 16'h000B, 1'b0, 1'b1, 1'b0, 1'b1);
    send(OP_DEC, 16'h8000, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
    send(OP_ILL, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // coe masking, inc saturation, signed-sub saturation to minimum
    do_clr();
    send(OP_UADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(OP_INC,  16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
    send(OP_SSUB, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();

    // stall with out_ready low for 5 edges, then full-rate release
    bus.out_ready = 1'b0;
    fork
      begin
        send(OP_ACC,  16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h8002, 1'b0, 1'b0, 1'b0, 1'b1);
        send(OP_ACC,  16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h8004, 1'b0, 1'b0, 1'b0, 1'b1);
        send(OP_SADD, 16'h0100, 16'h0200, 1'b0, 1'b1, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b1);
        send(OP_ACC,  16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0310, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("stall_in_ready", bus.in_ready, 1'b0);
        check1("stall_out_valid", bus.out_valid, 1'b1);
        checkw("stall_C_held", bus.C, 16'h8002);
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check1("burst_out_valid", bus.out_valid, 1'b1);
        end
      end
    join
    drain();

    // asynchronous reset with a result held and stickies set
    bus.out_ready = 1'b0;
    send(OP_ACC, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h830F, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !bus.out_valid; i++) @(negedge clk);
    check1("pre_rst_out_valid", bus.out_valid, 1'b1);
    check1("pre_rst_vout", bus.vout, 1'b1);
    check1("pre_rst_ovf_sticky", bus.ovf_sticky, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("arst_out_valid", bus.out_valid, 1'b0);
    checkw("arst_C", bus.C, 16'h0000);
    check1("arst_vout", bus.vout, 1'b0);
    check1("arst_cout", bus.cout, 1'b0);
    check1("arst_err", bus.err, 1'b0);
    check1("arst_ovf_sticky", bus.ovf_sticky, 1'b0);
    check1("arst_carry_sticky", bus.carry_sticky, 1'b0);
    exp_q.delete();
    m_ovf   = 1'b0;
    m_carry = 1'b0;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    send(OP_ACC, 16'h0003, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arith_pipe.md
# arith_pipe

Parametrised, pipelined successor to the team's 16-bit combinational arithmetic unit. It performs signed and unsigned add, subtract, increment and decrement, plus a new accumulate mode, over WIDTH bits. Operands enter through a valid/ready handshake and results leave through one, with two register stages in between. Over the combinational unit it adds optional saturation, sticky status flags, an illegal-op error and a clearable accumulator. It sits between the operand/register-file logic and result writeback.

## Interface
- WIDTH, 16: operand/result width; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- A, B  in  WIDTH  operands.
- code  in  3  opcode: 000 signed add, 001 unsigned add, 010 signed sub, 011 unsigned sub, 100 inc, 101 dec, 110 accumulate, 111 illegal.
- cin  in  1  carry-in (add, sub, accumulate).
- coe  in  1  carry/overflow enable; 0 forces cout and vout to 0.
- sat  in  1  saturate on overflow/carry/borrow.
- clr  in  1  synchronous clear of the accumulator and sticky flags.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- C  out  WIDTH  result.
- vout, cout, err  out  1  signed overflow, carry/no-borrow, illegal opcode.
- ovf_sticky, carry_sticky  out  1  OR of vout and of cout since the last clr.

## Operation
- All arithmetic is done at WIDTH+1 bits; total[WIDTH] is the raw carry.
- Per opcode:
  - Signed add: total = A + B + cin; vout = (A[msb]==B[msb]) && (C[msb]!=A[msb]).
  - Unsigned add: as signed add; cout = total[WIDTH].
  - Signed sub: total = A + ~B + cin (cin=1 gives a true subtract); vout = (A[msb]!=B[msb]) && (C[msb]!=A[msb]).
  - Unsigned sub: as signed sub; cout = total[WIDTH] (1 = no borrow).
  - Inc: total = A + 1; vout when A is the signed maximum; cout = total[WIDTH].
  - Dec: total = A + all-ones; vout when A is the signed minimum; cout = total[WIDTH].
  - Accumulate: total = acc + A + cin; vout uses the signed-add rule with acc as the first operand; cout = total[WIDTH]. B is ignored.
  - Illegal (111): C = 0, vout = cout = 0, err = 1; acc is not updated.
- Saturation (sat=1), applied before coe masking:
  - Signed ops with overflow: C = signed max if A[msb] (acc[msb] for accumulate) was 0, else signed min.
  - Unsigned add with carry: C = all-ones.
  - Unsigned sub with borrow (cout=0): C = 0.
  - vout and cout still report the raw condition.
- coe=0: vout and cout are driven 0, so the sticky flags do not set.
- acc loads the final C whenever a non-illegal result is loaded into S2. Back-to-back accumulates therefore chain with no gaps.
- Sticky flags set when S2 loads a result with vout/cout = 1.
- clr clears acc and both sticky flags. On the same cycle as an S2 load, the load's update wins.

## Timing
- Pipeline advance: en = !out_valid || out_ready. in_ready = en (combinational).
- S1 captures operands, code and control bits when in_valid && en.
- S2 computes from S1 and captures when en; s1 valid moves into out_valid.
- Latency: the result is on C/out_valid after the 2nd rising edge, counting the accepting edge.
- Throughput is one op per cycle while out_ready is high.
- Stall: out_valid && !out_ready holds all stages. Outputs stay stable, with no loss or duplication.
- Reset: out_valid=0, C=0, vout=cout=err=0, stickies=0, acc=0, S1 invalid. in_ready=1 once rst_n is high.
- Reset asserted mid-operation discards in-flight beats immediately and asynchronously.
- Inputs are sampled only on the accepting edge; A/B/code may change freely otherwise.

## Structure
- Package arith_pkg holds:
  - op code localparams: OP_SADD, OP_UADD, OP_SSUB, OP_USUB, OP_INC, OP_DEC, OP_ACC, OP_ILL.
  - WIDTH-independent helpers for signed max/min constants.
- Sub-module arith_core: purely combinational, parameter WIDTH. Inputs: A, B, acc, code, cin, sat. Outputs: C, vout, cout, err (coe masking excluded).
- The arith_pipe top holds the S1/S2 registers, handshake, acc and sticky flags.

## Test plan
- Signed add 0x7FFF+0x0001, cin=0, coe=1, sat=0 → C=0x8000, vout=1, ovf_sticky=1 two edges after acceptance. Same with sat=1 → C=0x7FFF, vout=1.
- Unsigned sub A=0x0003, B=0x0005, cin=1 → C=0xFFFE, cout=0. With sat=1 → C=0x0000.
- clr, then back-to-back accumulate A=0x0005, 0x0007, 0xFFFF, cin=0 → C=0x0005, 0x000C, 0x000B on consecutive cycles.
- Dec A=0x8000 → C=0x7FFF, vout=1. code 111 → C=0, err=1. coe=0 on a 0xFFFF+0x0001 unsigned add → C=0x0000, cout=0, carry_sticky unchanged.
- Issue 4 ops with out_ready low for 5 cycles → in_ready drops once S1 and S2 are full; results emerge in order with no loss or duplication; throughput is 1/cycle after release.
- Assert rst_n low while out_valid=1 and stickies are set → all outputs and acc go to 0 immediately; the first op after release behaves as from reset.
